// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - multi-cycle load/store unit with req/resp memory handshake and watchdog
module lsu_mem_port #(
    parameter int ADDR_WIDTH      = 32,
    parameter int TIMEOUT         = 255,
    parameter bit WAIT_WRITE_RESP = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic                  i_ren,
    input  logic                  i_wen,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [31:0]           o_rdata,
    output logic                  o_trap,
    output logic [1:0]            o_trap_cause,
    output logic                  o_mem_req,
    input  logic                  i_mem_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_wen,
    output logic [31:0]           o_mem_wdata,
    output logic [3:0]            o_mem_mask,
    input  logic                  i_mem_valid,
    input  logic [31:0]           i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_MISALGN = 2'd1;
    localparam logic [1:0] CAUSE_FAULT   = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd3;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
    logic [1:0]              off_q, off_d;
    logic [2:0]              funct3_q, funct3_d;
    logic                    ren_q, ren_d;
    logic                    wen_q, wen_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              mask_q, mask_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    trap_q, trap_d;
    logic [1:0]              cause_q, cause_d;

    // Request decode of the incoming access: legality, alignment, lane mask, lane-shifted store data
    logic        legal_load, legal_store, illegal, misaligned;
    logic [3:0]  mask_in;
    logic [31:0] wdata_sized;
    always_comb begin
        legal_load  = 1'b0;
        legal_store = 1'b0;
        case (i_funct3)
            3'b000, 3'b001, 3'b010: begin
                legal_load  = 1'b1;
                legal_store = 1'b1;
            end
            3'b100, 3'b101: legal_load = 1'b1;
            default: ;
        endcase
        illegal = (i_ren & i_wen) | (i_ren & ~legal_load) | (i_wen & ~legal_store);
        misaligned = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                     ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
        mask_in     = 4'b1111;
        wdata_sized = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                mask_in     = 4'b0001 << i_addr[1:0];
                wdata_sized = {24'b0, i_wdata[7:0]};
            end
            2'b01: begin
                mask_in     = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_sized = {16'b0, i_wdata[15:0]};
            end
            default: ;
        endcase
    end

    // Load path: move the addressed lane down to bit 0, then sign/zero extend by funct3
    logic [31:0] rd_shift, rd_ext;
    always_comb begin
        rd_shift = i_mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  rd_ext = {24'b0, rd_shift[7:0]};
            3'b101:  rd_ext = {16'b0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    logic timeout_hit;
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    // Next-state and datapath update for the IDLE/REQ/RESP/DONE access sequence
    always_comb begin
        state_d  = state_q;
        maddr_d  = maddr_q;
        off_d    = off_q;
        funct3_d = funct3_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        trap_d   = trap_q;
        cause_d  = cause_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid && (i_ren || i_wen)) begin
                    maddr_d  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
                    off_d    = i_addr[1:0];
                    funct3_d = i_funct3;
                    ren_d    = i_ren;
                    wen_d    = i_wen;
                    wdata_d  = wdata_sized << {i_addr[1:0], 3'b000};
                    mask_d   = mask_in;
                    cnt_d    = '0;
                    rdata_d  = '0;
                    trap_d   = 1'b0;
                    cause_d  = CAUSE_NONE;
                    if (illegal) begin
                        trap_d  = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                        state_d = S_DONE;
                    end else if (misaligned) begin
                        trap_d  = 1'b1;
                        cause_d = CAUSE_MISALGN;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_ONE;
                if (i_mem_ready && wen_q && !WAIT_WRITE_RESP) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    trap_d  = 1'b1;
                    cause_d = CAUSE_FAULT;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else if (i_mem_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + CNT_ONE;
                if (i_mem_valid) begin
                    if (ren_q) rdata_d = rd_ext;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    trap_d  = 1'b1;
                    cause_d = CAUSE_FAULT;
                    rdata_d = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            maddr_q  <= '0;
            off_q    <= '0;
            funct3_q <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            trap_q   <= 1'b0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state_q  <= state_d;
            maddr_q  <= maddr_d;
            off_q    <= off_d;
            funct3_q <= funct3_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            trap_q   <= trap_d;
            cause_q  <= cause_d;
        end
    end

    assign o_mem_req    = (state_q == S_REQ);
    assign o_done       = (state_q == S_DONE);
    assign o_busy       = ((state_q == S_IDLE) & i_valid & (i_ren | i_wen)) |
                          (state_q == S_REQ) | (state_q == S_RESP);
    assign o_rdata      = rdata_q;
    assign o_trap       = trap_q;
    assign o_trap_cause = cause_q;
    assign o_mem_addr   = maddr_q;
    assign o_mem_wen    = wen_q;
    assign o_mem_wdata  = wdata_q;
    assign o_mem_mask   = mask_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - directed vector bench for lsu_mem_port
module tb_lsu_mem_port;

    logic        clk;
    logic        rst;

    logic        i_valid, i_ren, i_wen;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic        i_mem_ready, i_mem_valid;
    logic [31:0] i_mem_rdata;
    logic        o_busy, o_done, o_trap, o_mem_req, o_mem_wen;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [1:0]  o_trap_cause;
    logic [3:0]  o_mem_mask;

    logic        b_valid, b_ren, b_wen;
    logic [2:0]  b_funct3;
    logic [31:0] b_addr, b_wdata;
    logic        b_mem_ready, b_mem_valid;
    logic [31:0] b_mem_rdata;
    logic        b_busy, b_done, b_trap, b_mem_req, b_mem_wen;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata;
    logic [1:0]  b_trap_cause;
    logic [3:0]  b_mem_mask;

    int checks = 0;
    int errors = 0;

    lsu_mem_port #(.ADDR_WIDTH(32), .TIMEOUT(4), .WAIT_WRITE_RESP(1'b0)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_ren(i_ren), .i_wen(i_wen),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy),
        .o_done(o_done), .o_rdata(o_rdata), .o_trap(o_trap), .o_trap_cause(o_trap_cause),
        .o_mem_req(o_mem_req), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
        .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata)
    );

    lsu_mem_port dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .i_ren(b_ren), .i_wen(b_wen),
        .i_funct3(b_funct3), .i_addr(b_addr), .i_wdata(b_wdata), .o_busy(b_busy),
        .o_done(b_done), .o_rdata(b_rdata), .o_trap(b_trap), .o_trap_cause(b_trap_cause),
        .o_mem_req(b_mem_req), .i_mem_ready(b_mem_ready), .o_mem_addr(b_mem_addr),
        .o_mem_wen(b_mem_wen), .o_mem_wdata(b_mem_wdata), .o_mem_mask(b_mem_mask),
        .i_mem_valid(b_mem_valid), .i_mem_rdata(b_mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  f3;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          lat;
        logic        req;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        logic        trap;
        logic [1:0]  cause;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int          lat;
        logic        seen_req;
        logic [31:0] a_addr, a_wdata, d_rdata;
        logic [3:0]  a_mask;
        logic        a_wen, d_trap;
        logic [1:0]  d_cause;
        lat = -1; seen_req = 1'b0;
        a_addr = '0; a_wdata = '0; a_mask = '0; a_wen = 1'b0;
        d_rdata = '0; d_trap = 1'b0; d_cause = '0;
        i_valid = 1'b1; i_ren = v.ren; i_wen = v.wen; i_funct3 = v.f3;
        i_addr = v.addr; i_wdata = v.wdata;
        i_mem_ready = 1'b1; i_mem_valid = 1'b1; i_mem_rdata = v.mrd;
        for (int c = 0; c < 12 && lat < 0; c++) begin
            @(negedge clk);
            if (o_mem_req && !seen_req) begin
                seen_req = 1'b1;
                a_addr = o_mem_addr; a_wdata = o_mem_wdata; a_mask = o_mem_mask; a_wen = o_mem_wen;
            end
            if (o_done) begin
                lat = c; d_rdata = o_rdata; d_trap = o_trap; d_cause = o_trap_cause;
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_mem_valid = 1'b0; i_mem_ready = 1'b0;
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_req_seen", idx), 32'(seen_req), 32'(v.req));
        if (v.req) begin
            chk($sformatf("v%0d_mem_addr", idx), a_addr, v.maddr);
            chk($sformatf("v%0d_mem_mask", idx), 32'(a_mask), 32'(v.mask));
            chk($sformatf("v%0d_mem_wdata", idx), a_wdata, v.mwdata);
            chk($sformatf("v%0d_mem_wen", idx), 32'(a_wen), 32'(v.wen));
        end
        chk($sformatf("v%0d_rdata", idx), d_rdata, v.rdata);
        chk($sformatf("v%0d_trap", idx), 32'(d_trap), 32'(v.trap));
        chk($sformatf("v%0d_cause", idx), 32'(d_cause), 32'(v.cause));
    endtask

    task automatic access_b(input string nm, input logic ren, input logic wen,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] mrd, input int rdy_c, input int mv_c,
                            input int exp_done, input logic [31:0] exp_rdata);
        int          done_c;
        logic [31:0] d_rdata;
        logic        d_trap;
        done_c = -1; d_rdata = '0; d_trap = 1'b1;
        b_ren = ren; b_wen = wen; b_funct3 = 3'b010; b_addr = addr; b_wdata = wdata;
        b_mem_rdata = mrd;
        for (int c = 0; c < 20 && done_c < 0; c++) begin
            b_valid = 1'b1;
            b_mem_ready = (c == rdy_c);
            b_mem_valid = (c == mv_c);
            @(negedge clk);
            if (b_done) begin
                done_c = c; d_rdata = b_rdata; d_trap = b_trap;
            end
            @(posedge clk); #1;
        end
        b_valid = 1'b0; b_mem_ready = 1'b0; b_mem_valid = 1'b0;
        chk({nm, "_done_cycle"}, 32'(done_c), 32'(exp_done));
        chk({nm, "_rdata"}, d_rdata, exp_rdata);
        chk({nm, "_trap"}, 32'(d_trap), 32'd0);
    endtask

    initial begin
        int          done_c;
        int          req_cycles;
        logic        bad_done;
        logic [31:0] d_rdata;
        logic        d_trap;
        logic [1:0]  d_cause;

        //            f3     ren   wen   addr        wdata         mrd          lat req  maddr       mwdata        mask   rdata         trap  cause
        vecs[0]  = '{3'b010, 1'b1, 1'b0, 32'h1000, 32'h0,        32'hDEADBEEF, 3, 1'b1, 32'h1000, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 2'd0};
        vecs[1]  = '{3'b000, 1'b1, 1'b0, 32'h1003, 32'h0,        32'h80123456, 3, 1'b1, 32'h1000, 32'h0,        4'h8, 32'hFFFFFF80, 1'b0, 2'd0};
        vecs[2]  = '{3'b100, 1'b1, 1'b0, 32'h1003, 32'h0,        32'h80123456, 3, 1'b1, 32'h1000, 32'h0,        4'h8, 32'h00000080, 1'b0, 2'd0};
        vecs[3]  = '{3'b001, 1'b1, 1'b0, 32'h1002, 32'h0,        32'h80011234, 3, 1'b1, 32'h1000, 32'h0,        4'hC, 32'hFFFF8001, 1'b0, 2'd0};
        vecs[4]  = '{3'b101, 1'b1, 1'b0, 32'h1002, 32'h0,        32'h80011234, 3, 1'b1, 32'h1000, 32'h0,        4'hC, 32'h00008001, 1'b0, 2'd0};
        vecs[5]  = '{3'b000, 1'b1, 1'b0, 32'h1001, 32'h0,        32'h12345678, 3, 1'b1, 32'h1000, 32'h0,        4'h2, 32'h00000056, 1'b0, 2'd0};
        vecs[6]  = '{3'b001, 1'b0, 1'b1, 32'h2002, 32'h0000ABCD, 32'h0,        2, 1'b1, 32'h2000, 32'hABCD0000, 4'hC, 32'h0,        1'b0, 2'd0};
        vecs[7]  = '{3'b000, 1'b0, 1'b1, 32'h2001, 32'hFFFFFF5A, 32'h0,        2, 1'b1, 32'h2000, 32'h00005A00, 4'h2, 32'h0,        1'b0, 2'd0};
        vecs[8]  = '{3'b010, 1'b0, 1'b1, 32'h2004, 32'h12345678, 32'h0,        2, 1'b1, 32'h2004, 32'h12345678, 4'hF, 32'h0,        1'b0, 2'd0};
        vecs[9]  = '{3'b010, 1'b1, 1'b0, 32'h1002, 32'h0,        32'hDEADBEEF, 1, 1'b0, 32'h0,    32'h0,        4'h0, 32'h0,        1'b1, 2'd1};
        vecs[10] = '{3'b001, 1'b1, 1'b0, 32'h1001, 32'h0,        32'hDEADBEEF, 1, 1'b0, 32'h0,    32'h0,        4'h0, 32'h0,        1'b1, 2'd1};
        vecs[11] = '{3'b011, 1'b1, 1'b0, 32'h1000, 32'h0,        32'hDEADBEEF, 1, 1'b0, 32'h0,    32'h0,        4'h0, 32'h0,        1'b1, 2'd3};
        vecs[12] = '{3'b010, 1'b1, 1'b1, 32'h1000, 32'h0,        32'hDEADBEEF, 1, 1'b0, 32'h0,    32'h0,        4'h0, 32'h0,        1'b1, 2'd3};
        vecs[13] = '{3'b100, 1'b0, 1'b1, 32'h2000, 32'h000000AA, 32'h0,        1, 1'b0, 32'h0,    32'h0,        4'h0, 32'h0,        1'b1, 2'd3};
        vecs[14] = '{3'b001, 1'b0, 1'b1, 32'h2003, 32'h0000ABCD, 32'h0,        1, 1'b0, 32'h0,    32'h0,        4'h0, 32'h0,        1'b1, 2'd1};

        rst = 1'b1;
        i_valid = 1'b0; i_ren = 1'b0; i_wen = 1'b0; i_funct3 = '0; i_addr = '0; i_wdata = '0;
        i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = '0;
        b_valid = 1'b0; b_ren = 1'b0; b_wen = 1'b0; b_funct3 = '0; b_addr = '0; b_wdata = '0;
        b_mem_ready = 1'b0; b_mem_valid = 1'b0; b_mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_mem_req", 32'(o_mem_req), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_trap", 32'(o_trap), 32'd0);
        chk("rst_cause", 32'(o_trap_cause), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'd0);
        chk("rst_mem_mask", 32'(o_mem_mask), 32'd0);
        chk("rst_mem_wen", 32'(o_mem_wen), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) apply_vec(vecs[i], i);

        // valid with neither ren nor wen is ignored
        i_valid = 1'b1; i_ren = 1'b0; i_wen = 1'b0;
        bad_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (o_done || o_mem_req || o_busy) bad_done = 1'b1;
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        chk("nop_ignored", 32'(bad_done), 32'd0);

        // store stalled by ready low for cycles 1-3: request fields stay stable
        i_ren = 1'b0; i_wen = 1'b1; i_funct3 = 3'b010; i_addr = 32'h3000; i_wdata = 32'hCAFEF00D;
        i_mem_valid = 1'b0;
        done_c = -1; d_trap = 1'b1;
        for (int c = 0; c < 8; c++) begin
            i_valid = (done_c < 0);
            i_mem_ready = (c == 4);
            @(negedge clk);
            if (c == 0) chk("stall_busy_c0", 32'(o_busy), 32'd1);
            if (c >= 1 && c <= 4) begin
                chk($sformatf("stall_req_c%0d", c), 32'(o_mem_req), 32'd1);
                chk($sformatf("stall_addr_c%0d", c), o_mem_addr, 32'h3000);
                chk($sformatf("stall_mask_c%0d", c), 32'(o_mem_mask), 32'hF);
                chk($sformatf("stall_wdata_c%0d", c), o_mem_wdata, 32'hCAFEF00D);
                chk($sformatf("stall_busy_c%0d", c), 32'(o_busy), 32'd1);
            end
            if (o_done && done_c < 0) begin
                done_c = c; d_trap = o_trap;
                chk("done_busy", 32'(o_busy), 32'd0);
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_mem_ready = 1'b0;
        chk("stall_done_cycle", 32'(done_c), 32'd5);
        chk("stall_trap", 32'(d_trap), 32'd0);

        // watchdog in REQ: ready never high, TIMEOUT=4
        for (int pass = 0; pass < 2; pass++) begin
            i_ren = 1'b1; i_wen = 1'b0; i_funct3 = 3'b010; i_addr = 32'h1000; i_wdata = '0;
            i_mem_rdata = 32'hDEADBEEF; i_mem_valid = 1'b0;
            done_c = -1; req_cycles = 0; d_rdata = 32'hFFFFFFFF; d_trap = 1'b0; d_cause = '0;
            for (int c = 0; c < 10; c++) begin
                i_valid = (done_c < 0);
                i_mem_ready = (pass == 1) && (c == 1);
                @(negedge clk);
                if (o_mem_req) req_cycles++;
                if (o_done && done_c < 0) begin
                    done_c = c; d_rdata = o_rdata; d_trap = o_trap; d_cause = o_trap_cause;
                end
                @(posedge clk); #1;
            end
            i_valid = 1'b0; i_mem_ready = 1'b0;
            chk($sformatf("wd%0d_req_cycles", pass), 32'(req_cycles), (pass == 0) ? 32'd4 : 32'd1);
            chk($sformatf("wd%0d_done_cycle", pass), 32'(done_c), 32'd5);
            chk($sformatf("wd%0d_trap", pass), 32'(d_trap), 32'd1);
            chk($sformatf("wd%0d_cause", pass), 32'(d_cause), 32'd2);
            chk($sformatf("wd%0d_rdata", pass), d_rdata, 32'd0);
        end

        // reset while in RESP, stray response afterwards, then a fresh load
        i_ren = 1'b1; i_wen = 1'b0; i_funct3 = 3'b010; i_addr = 32'h1000;
        i_mem_rdata = 32'hBAD0BAD0;
        done_c = -1; bad_done = 1'b0; d_rdata = '0;
        for (int c = 0; c < 13; c++) begin
            rst = (c == 3);
            i_valid = (c <= 3) || (c >= 6 && done_c < 0);
            if (c == 6) begin
                i_addr = 32'h1004;
                i_mem_rdata = 32'h11223344;
            end
            i_mem_ready = (c == 1) || (c == 7);
            i_mem_valid = (c == 5) || (c == 8);
            @(negedge clk);
            if (c == 4 || c == 5) begin
                chk($sformatf("rst_mid_req_c%0d", c), 32'(o_mem_req), 32'd0);
                chk($sformatf("rst_mid_busy_c%0d", c), 32'(o_busy), 32'd0);
            end
            if (o_done && c < 6) bad_done = 1'b1;
            if (o_done && c >= 6 && done_c < 0) begin
                done_c = c; d_rdata = o_rdata;
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; i_valid = 1'b0; i_mem_ready = 1'b0; i_mem_valid = 1'b0;
        chk("rst_mid_no_done", 32'(bad_done), 32'd0);
        chk("rst_mid_new_done", 32'(done_c), 32'd9);
        chk("rst_mid_new_rdata", d_rdata, 32'h11223344);

        // default configuration: store waits for ack; long load does not time out
        access_b("b_store_ack", 1'b0, 1'b1, 32'h4000, 32'h55AA55AA, 32'h0, 1, 5, 6, 32'h0);
        access_b("b_load_slow", 1'b1, 1'b0, 32'h4008, 32'h0, 32'h0F0F0F0F, 3, 12, 13, 32'h0F0F0F0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Multi-cycle load/store unit between the hart's memory-access stage and a data memory with a request/response handshake and variable latency.
- Successor to the single-cycle combinational dmem path.
- Handles byte, half and word accesses: lane alignment, masking, load sign/zero extension, and misalignment/illegal-op traps.
- Adds a response-timeout watchdog, a configurable store-completion mode, and a busy/stall signal to the pipeline.

Parameters:
ADDR_WIDTH, 32, width of the data address path (data width fixed at 32).
TIMEOUT, 255, maximum cycles spent in REQ+RESP before an access-fault trap; 0 disables the watchdog.
WAIT_WRITE_RESP, 1, 1 = stores wait for i_mem_valid ack; 0 = stores complete on request acceptance.

Ports:
i_clk  in  1  global clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  memory-stage instruction is a load/store; held until o_done
i_ren  in  1  load
i_wen  in  1  store
i_funct3  in  3  RV32I funct3 (size/sign)
i_addr  in  ADDR_WIDTH  effective byte address (ALU result)
i_wdata  in  32  store data (rs2)
o_busy  out  1  stall request to pipeline
o_done  out  1  one-cycle completion pulse
o_rdata  out  32  extended load result, valid with o_done
o_trap  out  1  access trapped, valid with o_done
o_trap_cause  out  2  0 none, 1 misaligned, 2 access fault (timeout), 3 illegal
o_mem_req  out  1  request valid
i_mem_ready  in  1  memory accepts request this cycle
o_mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
o_mem_wen  out  1  request is a write
o_mem_wdata  out  32  lane-shifted store data
o_mem_mask  out  4  byte-lane mask
i_mem_valid  in  1  response/ack valid
i_mem_rdata  in  32  read data

Behaviour:
- States: IDLE, REQ, RESP, DONE.
- Reset values: state IDLE; o_mem_req, o_done, o_trap 0; o_trap_cause 0; o_rdata, o_mem_addr, o_mem_wdata 0; o_mem_mask 0; o_mem_wen 0; timeout counter 0.
- IDLE, on i_valid: latch addr, wdata, funct3, ren and wen.
  - i_ren&i_wen, or invalid funct3: go to DONE with cause 3. Valid loads are 000, 001, 010, 100, 101; valid stores are 000, 001, 010.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): go to DONE with cause 1. No o_mem_req is ever raised.
  - Otherwise: go to REQ and clear the timeout counter.
  - i_valid with neither ren nor wen: ignored, stay IDLE.
- REQ:
  - o_mem_req=1; addr, wen, wdata and mask are held stable until the edge where i_mem_ready=1.
  - On accept: a store with WAIT_WRITE_RESP=0 goes to DONE; everything else goes to RESP.
  - i_mem_valid is ignored in REQ.
- RESP:
  - o_mem_req=0.
  - i_mem_valid=1: capture and extend rdata (loads), then go to DONE.
- Watchdog (TIMEOUT>0): the counter increments every cycle in REQ/RESP. If the counter==TIMEOUT-1 and the access does not complete that cycle, go to DONE with cause 2. This gives exactly TIMEOUT cycles in REQ+RESP. o_rdata=0 on a trap.
- DONE: o_done=1 for exactly one cycle, then IDLE.
  - i_valid is ignored in DONE. The pipeline advances on the edge ending DONE.
- o_busy (combinational) = (IDLE & i_valid & (i_ren|i_wen)) | REQ | RESP. It is 0 in DONE.
- Mask:
  - byte: 1<<addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- Store data: o_mem_wdata = i_wdata << (8*addr[1:0]); unused lanes are 0.
- Load data: shift i_mem_rdata right by 8*addr[1:0], then extend. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Minimum latencies from the i_valid cycle (cycle 0): trap → o_done at cycle 1; load with zero-wait memory → o_done at cycle 3; posted store → o_done at cycle 2.
- Reset mid-operation: the next cycle is IDLE with o_mem_req=0. Later i_mem_valid pulses are ignored in IDLE and produce no o_done.

Test Plan:
- lw 0x1000: ready=1 at cycle 1, valid=1 with 0xDEADBEEF at cycle 2 → o_mem_req at cycle 1 with addr 0x1000, mask 1111; o_done at cycle 3 with rdata 0xDEADBEEF, trap 0.
- lb 0x1003 with i_mem_rdata 0x80123456 → mask 1000, addr 0x1000, rdata 0xFFFFFF80. Same access as lbu → 0x00000080. lh 0x1002 with 0x8001xxxx → 0xFFFF8001.
- sh 0x2002, wdata 0x0000ABCD, WAIT_WRITE_RESP=0, ready=1 at cycle 1 → o_mem_wen=1, mask 1100, wdata 0xABCD0000; o_done at cycle 2 with no i_mem_valid needed.
- lw 0x1002 → o_mem_req never asserted; o_done at cycle 1 with trap=1, cause 1. funct3=011 load → cause 3.
- i_mem_ready low for cycles 1–3, high at cycle 4 → addr, mask and wdata constant during cycles 1–4; o_busy=1 throughout. TIMEOUT=4 with ready never high → REQ during cycles 1–4, o_done at cycle 5 with cause 2.
- i_rst at cycle 3 while in RESP, then i_mem_valid at cycle 5 → o_mem_req=0 and state IDLE from cycle 4; no o_done; a new lw issued at cycle 6 completes normally.
